// File: rtl/write_driver_array.sv
// -----------------------------------------------------------------------------
// write_driver_array
//
// Clocked, multi-column SRAM write driver. One masked NCOL-wide word is
// captured per request through a req/ack handshake. The bitlines are then
// sequenced through precharge, drive and recovery phases whose lengths are set
// by parameters. Real-valued bitline levels go to the column mux and
// cell-array models.
//
// Ports:
//   clk      rising-edge clock for all state changes
//   rst_n    asynchronous active-low reset
//   wr_req   write request, only looked at while idle
//   wr_data  per-column data bit (1: bl=VDD/blb=VSS, 0: bl=VSS/blb=VDD)
//   wr_mask  per-column enable; masked-off columns are never driven
//   wr_ack   one-cycle pulse, the cycle after a request is captured
//   busy     high while precharge, drive or recovery is in progress
//   done     one-cycle pulse when a transaction completes
//   drv_en   per-column drive-active flag (drive phase and mask set)
//   bl_wr    bitline level per column
//   blb_wr   complement bitline level per column
// -----------------------------------------------------------------------------
module write_driver_array #(
    parameter int  NCOL    = 8,
    parameter int  PRE_CYC = 2,
    parameter int  DRV_CYC = 3,
    parameter int  REC_CYC = 1,
    parameter real VDD     = 1.5,
    parameter real VSS     = 0.0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_req,
    input  logic [NCOL-1:0] wr_data,
    input  logic [NCOL-1:0] wr_mask,
    output logic            wr_ack,
    output logic            busy,
    output logic            done,
    output logic [NCOL-1:0] drv_en,
    output real             bl_wr  [NCOL],
    output real             blb_wr [NCOL]
);

    if ((NCOL < 1) || (PRE_CYC < 1) || (DRV_CYC < 1) || (REC_CYC < 1)) begin : g_param_err
        $error("write_driver_array: NCOL, PRE_CYC, DRV_CYC and REC_CYC must all be >= 1");
    end

    localparam int MAX_CYC = (PRE_CYC > DRV_CYC) ?
                             ((PRE_CYC > REC_CYC) ? PRE_CYC : REC_CYC) :
                             ((DRV_CYC > REC_CYC) ? DRV_CYC : REC_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Terminal counts: the counter restarts at 0 on every phase entry.
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(DRV_CYC - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(REC_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        DRIVE = 2'd2,
        REC   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic            accept;
    logic            done_nxt;
    logic [NCOL-1:0] data_q;
    logic [NCOL-1:0] mask_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    accept  = 1'b1;
                    cnt_nxt = '0;
                    // An all-zero mask has nothing to drive, so the request
                    // completes immediately: ack and done land together.
                    if (wr_mask == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = PRE;
                    end
                end
            end
            PRE: begin
                if (cnt == PRE_LAST) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DRIVE: begin
                if (cnt == DRV_LAST) begin
                    state_nxt = REC;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            REC: begin
                if (cnt == REC_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            wr_ack <= 1'b0;
            done   <= 1'b0;
            drv_en <= '0;
            data_q <= '0;
            mask_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            wr_ack <= accept;
            done   <= done_nxt;
            if (accept) begin
                data_q <= wr_data;
                mask_q <= wr_mask;
            end
            // DRIVE is only entered from PRE, so mask_q is already valid here.
            drv_en <= (state_nxt == DRIVE) ? mask_q : '0;
        end
    end

    assign busy = (state != IDLE);

    // Levels are decoded from registered flags only. Each line can drop to
    // VSS only for its own data polarity, so bl and blb are never both low,
    // and reset forces both to VDD without waiting for a clock.
    always_comb begin
        for (int i = 0; i < NCOL; i++) begin
            bl_wr[i]  = (drv_en[i] && !data_q[i]) ? VSS : VDD;
            blb_wr[i] = (drv_en[i] &&  data_q[i]) ? VSS : VDD;
        end
    end

endmodule
